prf_wr_arbiter: RTL

PRF_WR_ARBITER -- requirements
Module: prf_wr_arbiter

---
 rtl/prf_wr_arbiter_if.sv | 43 ++++
 rtl/prf_wr_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/prf_wr_arbiter_if.sv
// Write-port bundle between the PRF write requesters and the banked register file.
// The arbiter takes the slave side.
interface prf_wr_arbiter_if #(
  parameter int PRF_WR_COUNT   = 8,
  parameter int PRF_BANK_COUNT = 4,
  parameter int PR_W           = 7,
  parameter int DATA_W         = 64
);
  localparam int RQ_W  = $clog2(PRF_WR_COUNT);
  localparam int ROW_W = PR_W - $clog2(PRF_BANK_COUNT);

  logic [PRF_WR_COUNT-1:0]               wr_req_valid_by_rq;
  logic [PRF_WR_COUNT-1:0][PR_W-1:0]     wr_req_PR_by_rq;
  logic [PRF_WR_COUNT-1:0][DATA_W-1:0]   wr_req_data_by_rq;
  logic [PRF_WR_COUNT-1:0]               wr_req_ready_by_rq;

  logic [PRF_BANK_COUNT-1:0]             prf_WEN_by_bank;
  logic [PRF_BANK_COUNT-1:0][ROW_W-1:0]  prf_waddr_by_bank;
  logic [PRF_BANK_COUNT-1:0][DATA_W-1:0] prf_wdata_by_bank;
  logic [PRF_BANK_COUNT-1:0][RQ_W-1:0]   prf_wr_rq_by_bank;

  modport master (
    output wr_req_valid_by_rq,
    output wr_req_PR_by_rq,
    output wr_req_data_by_rq,
    input  wr_req_ready_by_rq,
    input  prf_WEN_by_bank,
    input  prf_waddr_by_bank,
    input  prf_wdata_by_bank,
    input  prf_wr_rq_by_bank
  );

  modport slave (
    input  wr_req_valid_by_rq,
    input  wr_req_PR_by_rq,
    input  wr_req_data_by_rq,
    output wr_req_ready_by_rq,
    output prf_WEN_by_bank,
    output prf_waddr_by_bank,
    output prf_wdata_by_bank,
    output prf_wr_rq_by_bank
  );
endinterface

// File: rtl/prf_wr_arbiter.sv
// PRF write arbiter: per-requester in-order FIFOs feed per-bank round-robin arbiters.
// The bank write ports are registered one cycle after the grant.
module prf_wr_arbiter #(
  parameter int PRF_WR_COUNT             = 8,
  parameter int PRF_BANK_COUNT           = 4,
  parameter int PRF_WR_INPUT_BUFFER_SIZE = 2,
  parameter int PR_W                     = 7,
  parameter int DATA_W                   = 64
) (
  input  logic           CLK,
  input  logic           nRST,
  prf_wr_arbiter_if.slave wr_if
);
  localparam int RQ_W   = $clog2(PRF_WR_COUNT);
  localparam int BANK_W = $clog2(PRF_BANK_COUNT);
  localparam int ROW_W  = PR_W - BANK_W;
  localparam int DEPTH  = PRF_WR_INPUT_BUFFER_SIZE;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic [PR_W-1:0]   r_fifo_pr   [PRF_WR_COUNT][DEPTH];
  logic [DATA_W-1:0] r_fifo_data [PRF_WR_COUNT][DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr    [PRF_WR_COUNT];
  logic [PTR_W-1:0]  r_rd_ptr    [PRF_WR_COUNT];
  logic [CNT_W-1:0]  r_count     [PRF_WR_COUNT];
  logic [RQ_W-1:0]   r_rr_ptr    [PRF_BANK_COUNT];

  logic [PRF_WR_COUNT-1:0]               w_ready;
  logic [PRF_WR_COUNT-1:0]               w_enq;
  logic [PRF_WR_COUNT-1:0]               w_deq;
  logic [PRF_WR_COUNT-1:0]               w_head_vld;
  logic [PRF_WR_COUNT-1:0][PR_W-1:0]     w_head_pr;
  logic [PRF_WR_COUNT-1:0][DATA_W-1:0]   w_head_data;

  logic [PRF_BANK_COUNT-1:0]             w_gnt_vld;
  logic [PRF_BANK_COUNT-1:0][RQ_W-1:0]   w_gnt_rq;
  logic [PRF_BANK_COUNT-1:0][ROW_W-1:0]  w_gnt_row;
  logic [PRF_BANK_COUNT-1:0][DATA_W-1:0] w_gnt_data;

  logic [PRF_BANK_COUNT-1:0]             r_vld_p1;
  logic [PRF_BANK_COUNT-1:0][RQ_W-1:0]   r_rq_p1;
  logic [PRF_BANK_COUNT-1:0][ROW_W-1:0]  r_waddr_p1;
  logic [PRF_BANK_COUNT-1:0][DATA_W-1:0] r_wdata_p1;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (int'(p) == DEPTH - 1) return '0;
    return p + 1'b1;
  endfunction

  function automatic logic [RQ_W-1:0] rq_inc(input logic [RQ_W-1:0] q);
    if (int'(q) == PRF_WR_COUNT - 1) return '0;
    return q + 1'b1;
  endfunction

  // Stage p0: FIFO heads and enqueue qualification from registered occupancy
  always_comb begin
    w_ready     = '0;
    w_enq       = '0;
    w_head_vld  = '0;
    w_head_pr   = '0;
    w_head_data = '0;
    for (int r = 0; r < PRF_WR_COUNT; r++) begin
      w_ready[r]     = (r_count[r] < CNT_W'(DEPTH));
      w_enq[r]       = wr_if.wr_req_valid_by_rq[r] & w_ready[r];
      w_head_vld[r]  = (r_count[r] != '0);
      w_head_pr[r]   = r_fifo_pr[r][r_rd_ptr[r]];
      w_head_data[r] = r_fifo_data[r][r_rd_ptr[r]];
    end
  end

  // Per-bank round-robin search starting at the bank pointer; one head per requester
  // means a requester can match at most one bank, so no cross-bank check is needed.
  always_comb begin
    logic [RQ_W-1:0] w_idx;
    int              sum;
    w_idx      = '0;
    sum        = 0;
    w_deq      = '0;
    w_gnt_vld  = '0;
    w_gnt_rq   = '0;
    w_gnt_row  = '0;
    w_gnt_data = '0;
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      for (int k = 0; k < PRF_WR_COUNT; k++) begin
        sum = int'(r_rr_ptr[b]) + k;
        if (sum >= PRF_WR_COUNT) sum = sum - PRF_WR_COUNT;
        w_idx = RQ_W'(sum);
        if (!w_gnt_vld[b] && w_head_vld[w_idx] &&
            (w_head_pr[w_idx][BANK_W-1:0] == BANK_W'(b))) begin
          w_gnt_vld[b]  = 1'b1;
          w_gnt_rq[b]   = w_idx;
          w_gnt_row[b]  = w_head_pr[w_idx][PR_W-1:BANK_W];
          w_gnt_data[b] = w_head_data[w_idx];
          w_deq[w_idx]  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int r = 0; r < PRF_WR_COUNT; r++) begin
        r_wr_ptr[r] <= '0;
        r_rd_ptr[r] <= '0;
        r_count[r]  <= '0;
      end
    end else begin
      for (int r = 0; r < PRF_WR_COUNT; r++) begin
        if (w_enq[r]) r_wr_ptr[r] <= ptr_inc(r_wr_ptr[r]);
        if (w_deq[r]) r_rd_ptr[r] <= ptr_inc(r_rd_ptr[r]);
        if (w_enq[r] && !w_deq[r])
          r_count[r] <= r_count[r] + 1'b1;
        else if (!w_enq[r] && w_deq[r])
          r_count[r] <= r_count[r] - 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    for (int r = 0; r < PRF_WR_COUNT; r++) begin
      if (w_enq[r]) begin
        r_fifo_pr[r][r_wr_ptr[r]]   <= wr_if.wr_req_PR_by_rq[r];
        r_fifo_data[r][r_wr_ptr[r]] <= wr_if.wr_req_data_by_rq[r];
      end
    end
  end

  // Stage p1: registered bank write ports; reset also clears in-flight writes
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_vld_p1   <= '0;
      r_rq_p1    <= '0;
      r_waddr_p1 <= '0;
      r_wdata_p1 <= '0;
      for (int b = 0; b < PRF_BANK_COUNT; b++) r_rr_ptr[b] <= '0;
    end else begin
      r_vld_p1   <= w_gnt_vld;
      r_rq_p1    <= w_gnt_rq;
      r_waddr_p1 <= w_gnt_row;
      r_wdata_p1 <= w_gnt_data;
      for (int b = 0; b < PRF_BANK_COUNT; b++) begin
        if (w_gnt_vld[b]) r_rr_ptr[b] <= rq_inc(w_gnt_rq[b]);
      end
    end
  end

  assign wr_if.wr_req_ready_by_rq = w_ready;
  assign wr_if.prf_WEN_by_bank    = r_vld_p1;
  assign wr_if.prf_wr_rq_by_bank  = r_rq_p1;
  assign wr_if.prf_waddr_by_bank  = r_waddr_p1;
  assign wr_if.prf_wdata_by_bank  = r_wdata_p1;
endmodule
